i2c_phase_gen: RTL and testbench
================================

Name: i2c_phase_gen

Overview:
- Parametrised, runtime-selectable I2C timing generator; successor to the fixed 100k/400k bit-clock divider.
- Divides the system clock into four quarter-bit phases and emits one-cycle phase strobes plus an SCL reference level.
- Supports standard, fast and fast-plus rates, plus a custom divisor; divisor changes take effect only on bit boundaries.
- Supports slave clock stretching with a timeout. Sits between CLK and the I2C byte/bit engine.

Parameters:
- CLK_HZ, 200000000, system clock frequency (documentation only; divisor defaults derive from it).
- DIV_W, 12, width of the quarter-period counter and of div_cfg.
- DIV_STD, 500, quarter-period in CLK cycles for 100 kHz (200 MHz / (4 × 100 k)).
- DIV_FAST, 125, quarter-period for 400 kHz.
- DIV_FASTP, 50, quarter-period for 1 MHz.
- STRETCH_MAX, 20000, maximum stretch length in CLK cycles before timeout (100 us at 200 MHz).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RSTn  in  1  synchronous active-low reset.
- En  in  1  run enable; low holds the generator idle.
- mode  in  2  rate select: 0 = DIV_STD, 1 = DIV_FAST, 2 = DIV_FASTP, 3 = div_cfg.
- div_cfg  in  DIV_W  custom quarter-period, used when mode = 3.
- scl_in  in  1  sampled SCL bus line, asynchronous; used for stretch detection.
- ph_tick  out  1  one-cycle strobe at the end of each quarter phase.
- phase  out  2  current quarter phase: 0 = SCL low/setup, 1 = SCL low/data, 2 = SCL high/sample, 3 = SCL high/hold.
- bit_tick  out  1  one-cycle strobe when phase wraps from 3 to 0.
- scl_ref  out  1  desired SCL level: 1 in phases 2 and 3, else 0.
- stretching  out  1  high while a stretch hold is in progress.
- timeout  out  1  one-cycle strobe when a stretch exceeds STRETCH_MAX.

Behaviour:
- Reset (RSTn low at a CLK edge): cnt = 0, phase = 0, ph_tick = 0, bit_tick = 0, scl_ref = 0, stretching = 0, timeout = 0, stretch counter = 0, scl synchroniser = 2'b11. Active div latched to the mode 0 value.
- Reset applied mid-operation takes effect at the next edge; no partial strobes follow it.
- Active divisor Q:
  - Latched from mode/div_cfg while En = 0, and on the cycle bit_tick is asserted.
  - Never changes mid-bit.
  - mode 3 with div_cfg < 2 is clamped to Q = 2.
- En = 0: cnt, phase and stretch counter held at 0; all strobes 0; scl_ref = 0.
- En rising edge: counting starts in the same cycle. The first ph_tick occurs Q cycles after the first En-high edge.
- Counting:
  - Each enabled, non-stalled cycle: if cnt == Q-1, then cnt <= 0, ph_tick <= 1, phase <= phase + 1 (mod 4). Otherwise cnt <= cnt + 1.
  - bit_tick <= 1 when ph_tick fires with phase == 3.
  - Strobes are registered and last exactly one cycle.
- scl_ref is a registered decode of phase and changes in the same cycle as phase.
- scl_in passes through a 2-flop synchroniser giving scl_s; detection latency is 2 cycles.
- Stretch (state STALL):
  - Entered when phase == 2 and scl_s == 0.
  - cnt is held at 0, stretching = 1, and the stretch counter increments each cycle.
  - Exit to normal counting on the cycle after scl_s == 1. The phase-2 quarter then runs a full Q from that point.
  - If the stretch counter reaches STRETCH_MAX: timeout pulses for 1 cycle, stretching drops, and counting resumes as if SCL rose.
  - After a timeout, stretch detection is disabled until phase leaves 2.
  - The stretch counter clears on every phase change and when En = 0.
- State machine: IDLE (En = 0) -> RUN (En = 1). RUN -> STALL on the stretch condition. STALL -> RUN on scl_s high or on timeout. Any state -> IDLE when En = 0, evaluated before the count logic.
- Simultaneous events:
  - En falling on a tick cycle: the tick is suppressed and the generator goes IDLE.
  - A mode change on the bit_tick cycle: the new value is latched.

Test Plan:
- Reset and idle: RSTn = 0 for 3 cycles, then RSTn = 1, En = 0 -> all outputs 0 and phase = 0 for 100 cycles.
- Fast mode: mode = 1, En = 1, scl_in = 1 -> ph_tick every 125 cycles, bit_tick every 500 cycles, scl_ref high for 250 of every 500 cycles.
- Mode switch mid-bit: mode 0 -> 2 while phase = 1 -> current bit completes at Q = 500; next bit uses Q = 50 (bit_tick spacing 200).
- Custom clamp: mode = 3 with div_cfg = 0, then div_cfg = 1 -> ph_tick every 2 cycles in both cases.
- Clock stretch: mode 2, hold scl_in = 0 for 300 cycles from the phase 2 entry -> stretching high, no ph_tick. After release, ph_tick occurs exactly 50 cycles after stretching falls.
- Stretch timeout: STRETCH_MAX = 1000, scl_in held low -> timeout pulses once, 1000 cycles after stretching rises; phase advances to 3 after a further Q cycles.

Source files
------------

// File: rtl/i2c_phase_gen.sv
// I2C quarter-bit phase generator: divides CLK into four SCL phases with
// runtime-selectable rate, bit-aligned divisor updates and slave clock stretching.
module i2c_phase_gen #(
    parameter int unsigned CLK_HZ      = 200000000,
    parameter int unsigned DIV_W       = 12,
    parameter int unsigned DIV_STD     = CLK_HZ / (4 * 100000),
    parameter int unsigned DIV_FAST    = CLK_HZ / (4 * 400000),
    parameter int unsigned DIV_FASTP   = CLK_HZ / (4 * 1000000),
    parameter int unsigned STRETCH_MAX = 20000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             En,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             scl_in,
    output logic             ph_tick,
    output logic [1:0]       phase,
    output logic             bit_tick,
    output logic             scl_ref,
    output logic             stretching,
    output logic             timeout
);

    localparam int unsigned STW = $clog2(STRETCH_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [1:0]       st_q, st_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] sel_div;
    logic [1:0]       phase_q, phase_d;
    logic             ph_tick_q, ph_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             scl_ref_q, scl_ref_d;
    logic             stretching_q, stretching_d;
    logic             timeout_q, timeout_d;
    logic [STW-1:0]   str_cnt_q, str_cnt_d;
    logic             blk_q, blk_d;
    logic [1:0]       sync_q, sync_d;
    logic             scl_s;

    assign scl_s = sync_q[1];

    // Quarter-period requested by the rate inputs; custom values below 2 are clamped.
    always_comb begin
        sel_div = DIV_W'(DIV_STD);
        case (mode)
            2'd0:    sel_div = DIV_W'(DIV_STD);
            2'd1:    sel_div = DIV_W'(DIV_FAST);
            2'd2:    sel_div = DIV_W'(DIV_FASTP);
            default: sel_div = (div_cfg < DIV_W'(2)) ? DIV_W'(2) : div_cfg;
        endcase
    end

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        ph_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        timeout_d  = 1'b0;
        str_cnt_d  = str_cnt_q;
        blk_d      = blk_q;
        sync_d     = {sync_q[0], scl_in};

        // The divisor only moves while idle or on the first cycle of a new bit.
        if (!En || bit_tick_q) begin
            div_d = sel_div;
        end

        if (!En) begin
            st_d      = ST_IDLE;
            cnt_d     = '0;
            phase_d   = 2'd0;
            str_cnt_d = '0;
            blk_d     = 1'b0;
        end else begin
            case (st_q)
                ST_STALL: begin
                    cnt_d = '0;
                    if (scl_s) begin
                        st_d = ST_RUN;
                    end else if (str_cnt_q == STW'(STRETCH_MAX - 1)) begin
                        // Give up on the slave; resume as though SCL had risen.
                        st_d      = ST_RUN;
                        timeout_d = 1'b1;
                        blk_d     = 1'b1;
                        str_cnt_d = '0;
                    end else begin
                        str_cnt_d = str_cnt_q + STW'(1);
                    end
                end
                default: begin
                    st_d = ST_RUN;
                    if (phase_q == 2'd2 && !scl_s && !blk_q) begin
                        st_d      = ST_STALL;
                        cnt_d     = '0;
                        str_cnt_d = '0;
                    end else if (cnt_q == div_q - DIV_W'(1)) begin
                        cnt_d      = '0;
                        ph_tick_d  = 1'b1;
                        bit_tick_d = (phase_q == 2'd3);
                        phase_d    = phase_q + 2'd1;
                        str_cnt_d  = '0;
                        blk_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
            endcase
        end

        scl_ref_d    = phase_d[1];
        stretching_d = (st_d == ST_STALL);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            st_q         <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= DIV_W'(DIV_STD);
            phase_q      <= 2'd0;
            ph_tick_q    <= 1'b0;
            bit_tick_q   <= 1'b0;
            scl_ref_q    <= 1'b0;
            stretching_q <= 1'b0;
            timeout_q    <= 1'b0;
            str_cnt_q    <= '0;
            blk_q        <= 1'b0;
            sync_q       <= 2'b11;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            ph_tick_q    <= ph_tick_d;
            bit_tick_q   <= bit_tick_d;
            scl_ref_q    <= scl_ref_d;
            stretching_q <= stretching_d;
            timeout_q    <= timeout_d;
            str_cnt_q    <= str_cnt_d;
            blk_q        <= blk_d;
            sync_q       <= sync_d;
        end
    end

    assign ph_tick    = ph_tick_q;
    assign phase      = phase_q;
    assign bit_tick   = bit_tick_q;
    assign scl_ref    = scl_ref_q;
    assign stretching = stretching_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_i2c_phase_gen.sv
// Self-checking bench for i2c_phase_gen: scenario tasks plus randomized rate runs
// compared against a closed-form timing model.
module tb_i2c_phase_gen;

    localparam int SMAX = 1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] div_cfg = 12'd0;
    logic        scl_in = 1'b1;
    logic        ph_tick, bit_tick, scl_ref, stretching, timeout;
    logic [1:0]  phase;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    i2c_phase_gen #(.STRETCH_MAX(SMAX)) dut (
        .CLK(clk), .RSTn(rstn), .En(en), .mode(mode), .div_cfg(div_cfg), .scl_in(scl_in),
        .ph_tick(ph_tick), .phase(phase), .bit_tick(bit_tick), .scl_ref(scl_ref),
        .stretching(stretching), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Quarter period implied by a rate selection.
    function automatic int q_of(input int m, input int dc);
        case (m)
            0: return 500;
            1: return 125;
            2: return 50;
            default: return (dc < 2) ? 2 : dc;
        endcase
    endfunction

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ph_tick === 1'b1) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] o;
        rstn = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            o = {ph_tick, phase, bit_tick, scl_ref, stretching};
            n_chk++;
            if ({o, timeout} !== 7'd0) $display("FAIL reset_idle: got %b want 0", {o, timeout});
            else n_pass++;
        end
    endtask

    task automatic test_fast();
        int n0, t, hi, nb;
        mode = 2'd1;
        scl_in = 1'b1;
        idle(4);
        en = 1'b1;
        n0 = cyc;
        for (int m = 1; m <= 8; m++) begin
            wait_tick(200, t);
            n_chk++;
            if (t !== n0 + 125 * m) $display("FAIL fast_tick%0d: got %0d want %0d", m, t, n0 + 125 * m);
            else n_pass++;
            n_chk++;
            if (phase !== 2'(m % 4)) $display("FAIL fast_phase%0d: got %0d want %0d", m, phase, m % 4);
            else n_pass++;
            n_chk++;
            if (bit_tick !== (m % 4 == 0)) $display("FAIL fast_bit%0d: got %b", m, bit_tick);
            else n_pass++;
        end
        hi = 0;
        nb = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (scl_ref === 1'b1) hi++;
            if (bit_tick === 1'b1) nb++;
        end
        n_chk++;
        if (hi !== 250) $display("FAIL fast_scl_duty: got %0d want 250", hi);
        else n_pass++;
        n_chk++;
        if (nb !== 1) $display("FAIL fast_bit_count: got %0d want 1", nb);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_mode_switch();
        int n0, t, exp_t;
        mode = 2'd0;
        idle(4);
        en = 1'b1;
        n0 = cyc;
        for (int m = 1; m <= 8; m++) begin
            wait_tick(600, t);
            exp_t = (m <= 4) ? n0 + 500 * m : n0 + 2000 + 50 * (m - 4);
            n_chk++;
            if (t !== exp_t) $display("FAIL switch_tick%0d: got %0d want %0d", m, t, exp_t);
            else n_pass++;
            n_chk++;
            if (bit_tick !== (m % 4 == 0)) $display("FAIL switch_bit%0d: got %b", m, bit_tick);
            else n_pass++;
            if (m == 1) mode = 2'd2;
        end
        idle(2);
    endtask

    task automatic test_clamp();
        int n0, t;
        for (int v = 0; v < 2; v++) begin
            mode = 2'd3;
            div_cfg = 12'(v);
            idle(4);
            en = 1'b1;
            n0 = cyc;
            for (int m = 1; m <= 8; m++) begin
                wait_tick(5, t);
                n_chk++;
                if (t !== n0 + 2 * m) $display("FAIL clamp%0d_tick%0d: got %0d want %0d", v, m, t, n0 + 2 * m);
                else n_pass++;
            end
            n_chk++;
            if (bit_tick !== 1'b1) $display("FAIL clamp%0d_bit: got %b want 1", v, bit_tick);
            else n_pass++;
        end
        idle(2);
    endtask

    task automatic test_stretch();
        int n0, t, p, rise, fall, nhigh, nt;
        mode = 2'd2;
        scl_in = 1'b1;
        idle(4);
        en = 1'b1;
        n0 = cyc;
        wait_tick(60, t);
        wait_tick(60, t);
        p = t;
        scl_in = 1'b0;
        rise = -1; fall = -1; nhigh = 0; nt = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (stretching === 1'b1) begin
                if (rise < 0) rise = cyc;
                nhigh++;
            end else if (rise >= 0 && fall < 0) begin
                fall = cyc;
            end
            if (ph_tick === 1'b1) nt++;
            if (i == 300) scl_in = 1'b1;
            if (fall >= 0) break;
        end
        n_chk++;
        if (rise !== p + 3) $display("FAIL stretch_rise: got %0d want %0d", rise, p + 3);
        else n_pass++;
        n_chk++;
        if (fall !== p + 303) $display("FAIL stretch_fall: got %0d want %0d", fall, p + 303);
        else n_pass++;
        n_chk++;
        if (nhigh !== 300) $display("FAIL stretch_len: got %0d want 300", nhigh);
        else n_pass++;
        n_chk++;
        if (nt !== 0) $display("FAIL stretch_no_tick: got %0d want 0", nt);
        else n_pass++;
        wait_tick(60, t);
        n_chk++;
        if (t !== fall + 50) $display("FAIL stretch_resume: got %0d want %0d", t, fall + 50);
        else n_pass++;
        n_chk++;
        if (phase !== 2'd3) $display("FAIL stretch_phase: got %0d want 3", phase);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_timeout();
        int t, p, rise, to, nto, nhigh, tk;
        mode = 2'd2;
        scl_in = 1'b1;
        idle(4);
        en = 1'b1;
        wait_tick(60, t);
        wait_tick(60, t);
        p = t;
        scl_in = 1'b0;
        rise = -1; to = -1; nto = 0; nhigh = 0; tk = -1;
        for (int i = 1; i <= 1200; i++) begin
            @(negedge clk);
            if (stretching === 1'b1) begin
                if (rise < 0) rise = cyc;
                nhigh++;
            end
            if (timeout === 1'b1) begin
                if (to < 0) to = cyc;
                nto++;
            end
            if (ph_tick === 1'b1) begin
                tk = cyc;
                break;
            end
        end
        n_chk++;
        if (rise !== p + 3) $display("FAIL to_rise: got %0d want %0d", rise, p + 3);
        else n_pass++;
        n_chk++;
        if (to !== rise + SMAX) $display("FAIL to_time: got %0d want %0d", to, rise + SMAX);
        else n_pass++;
        n_chk++;
        if (nto !== 1) $display("FAIL to_count: got %0d want 1", nto);
        else n_pass++;
        n_chk++;
        if (nhigh !== SMAX) $display("FAIL to_stretch_len: got %0d want %0d", nhigh, SMAX);
        else n_pass++;
        n_chk++;
        if (tk !== p + 3 + SMAX + 50) $display("FAIL to_resume: got %0d want %0d", tk, p + 3 + SMAX + 50);
        else n_pass++;
        n_chk++;
        if (phase !== 2'd3) $display("FAIL to_phase: got %0d want 3", phase);
        else n_pass++;
        scl_in = 1'b1;
        idle(2);
    endtask

    task automatic test_en_drop();
        int n0;
        mode = 2'd3;
        div_cfg = 12'd7;
        idle(4);
        en = 1'b1;
        n0 = cyc;
        while (cyc < n0 + 6) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if ({ph_tick, phase, bit_tick, scl_ref} !== 5'd0)
                $display("FAIL en_drop%0d: got %b want 0", i, {ph_tick, phase, bit_tick, scl_ref});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int n0, t;
        mode = 2'd1;
        idle(4);
        en = 1'b1;
        n0 = cyc;
        wait_tick(200, t);
        while (cyc < n0 + 249) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({ph_tick, phase, bit_tick, scl_ref, stretching, timeout} !== 7'd0)
            $display("FAIL reset_mid: got %b want 0",
                     {ph_tick, phase, bit_tick, scl_ref, stretching, timeout});
        else n_pass++;
        rstn = 1'b1;
        idle(3);
    endtask

    task automatic test_random();
        int ma, mb, da, db, qa, qb, n0, sw, last, k, q, nfail;
        logic [4:0] got, want;
        logic [1:0] eph;
        logic etk;
        scl_in = 1'b1;
        for (int it = 0; it < 6; it++) begin
            ma = $urandom_range(1, 3);
            mb = $urandom_range(1, 3);
            da = $urandom_range(0, 30);
            db = $urandom_range(0, 30);
            qa = q_of(ma, da);
            qb = q_of(mb, db);
            mode = 2'(ma);
            div_cfg = 12'(da);
            idle(3);
            en = 1'b1;
            n0 = cyc;
            sw = n0 + $urandom_range(1, 4 * qa);
            last = n0 + 4 * qa + 8 * qb + 3;
            nfail = 0;
            while (cyc < last) begin
                @(negedge clk);
                if (cyc <= n0 + 4 * qa) begin
                    k = cyc - n0;
                    q = qa;
                end else begin
                    k = cyc - (n0 + 4 * qa);
                    q = qb;
                end
                eph = 2'((k / q) % 4);
                etk = (k > 0) && (k % q == 0);
                want = {etk, eph, etk && (eph == 2'd0), eph[1]};
                got = {ph_tick, phase, bit_tick, scl_ref};
                n_chk++;
                if (got !== want || stretching !== 1'b0 || timeout !== 1'b0) begin
                    if (nfail < 5)
                        $display("FAIL rand%0d cyc %0d: got %b want %b (qa %0d qb %0d)",
                                 it, cyc - n0, got, want, qa, qb);
                    nfail++;
                end else n_pass++;
                if (cyc == sw) begin
                    mode = 2'(mb);
                    div_cfg = 12'(db);
                end
            end
            idle(2);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fast();
        test_mode_switch();
        test_clamp();
        test_stretch();
        test_timeout();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
